instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the control-unit decoder: accepts decoded instruction fields (Op, Funct, Cond, registers, immediates) over a valid/ready handshake.
- Packs each set of fields into a 32-bit ARM-subset machine word.
- Writes the words sequentially into instruction memory through a registered write port with its own valid/ready handshake.
- Used by the program loader and testbenches to fill imem before the CPU is released from reset.

Parameters:
- AW, 6, instruction-memory word-address width.
- DEPTH, 64, number of words loadable before FULL; 1 <= DEPTH <= 2**AW.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous; returns the address counter to 0 and leaves FULL.
- in_valid  in  1  field set present.
- in_ready  out  1  encoder can accept a field set.
- Op  in  2  00 DP, 01 memory, 10 branch.
- Funct  in  6  DP: {I,cmd[3:0],S}; mem: {~I,P,U,B,W,L}; branch: Funct[5:4]={1,L}.
- Cond  in  4  condition field.
- Rn  in  4  first source register.
- Rd  in  4  destination register.
- Src2  in  12  DP/mem operand-2 field.
- Imm24  in  24  branch offset.
- mem_valid  out  1  mem_addr/mem_wdata hold a word to write.
- mem_ready  in  1  instruction memory accepts the word this cycle.
- mem_addr  out  AW  word address of the current word.
- mem_wdata  out  32  encoded instruction.
- full  out  1  DEPTH words written.
- err  out  1  one-cycle pulse on a rejected field set (optional feature only).

Behaviour:
Reset (reset=0, asynchronous):
- mem_valid=0, mem_addr=0, mem_wdata=0, full=0, err=0.
- Internal word counter = 0; state LOAD.

Encoding (combinational from the inputs, registered on accept):
- DP/mem: {Cond, Op, Funct, Rn, Rd, Src2}.
- Branch: {Cond, 2'b10, Funct[5:4], Imm24}.

Handshakes:
- Input transfer when in_valid & in_ready.
- Output transfer when mem_valid & mem_ready.
- in_ready = (state==LOAD) & (~mem_valid | mem_ready).
- This gives single-stage pipelined flow: one word per cycle at full throughput.

Latency and ordering:
- An accepted field set appears on mem_wdata with mem_valid=1 the next cycle.
- mem_addr is the counter value at accept time.
- mem_valid, mem_addr and mem_wdata are held stable while mem_valid & ~mem_ready.

Counter and state machine:
- Counter increments by 1 on each output transfer.
- LOAD -> FULL on the output transfer that makes the counter equal DEPTH.
- In FULL: full=1, in_ready=0, no new words are accepted, counter stays at DEPTH.
- mem_addr is not advanced past DEPTH-1.
- FULL -> LOAD only on clear. Clear sets the counter to 0 and full to 0.

Boundary conditions:
- Clear with a word pending (mem_valid=1): the pending word is dropped (mem_valid=0) and the counter goes to 0.
- Clear takes priority over a simultaneous input or output transfer.
- Simultaneous output transfer and input accept in LOAD: the new word is registered with address counter+1 and mem_valid stays 1.
- If DEPTH = 2**AW, address wrap to 0 never occurs because FULL blocks it.
- Reset mid-transfer: the pending word is discarded and nothing is retained.

Optional Feature:
- Macro: ENC_LEGAL_CHECK_EN.
- Defined: a field set is rejected when either condition holds:
  - Op==11, or
  - Op==00 and Funct[4:1] is not in {0100 ADD, 0010 SUB, 0000 AND, 1100 ORR}.
- On a rejected field set:
  - It is accepted (handshake completes).
  - No word is produced and the counter is unchanged.
  - err=1 for exactly the next cycle.
- Undefined: all Op/Funct values are encoded verbatim; err is tied to 0.

Test Plan:
- Reset then DP ADD: Cond=1110, Op=00, Funct=101000, Rn=0, Rd=1, Src2=0x005 -> next cycle mem_valid=1, mem_addr=0, mem_wdata=0xE2801005.
- Branch: Cond=1110, Op=10, Funct=100000, Imm24=0xFFFFFE -> mem_wdata=0xEAFFFFFE; LDR Rd=2, Rn=0, Src2=0, Funct=011001 -> 0xE5902000 at the next address.
- Backpressure: hold mem_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, mem_wdata and mem_addr stable, one word written when mem_ready=1.
- Fill with DEPTH=4 streaming at mem_ready=1 -> addresses 0,1,2,3 back-to-back, full=1 after the 4th write, in_ready=0; clear -> full=0 and the next word is written at address 0.
- Clear while mem_valid=1 & mem_ready=0 -> mem_valid=0 next cycle, counter 0, no write.
- With ENC_LEGAL_CHECK_EN: Op=11 or Op=00 with Funct[4:1]=1111 -> err pulses 1 cycle, no mem_valid, counter unchanged; without the macro -> the word is written verbatim.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded ARM-subset instruction fields into
// 32-bit machine words and streams them into instruction memory.
// Words are written at consecutive addresses from 0 until DEPTH words have
// been written. The loader then stops accepting input until clear.
// Optional macro ENC_LEGAL_CHECK_EN: field sets that are not legal are
// consumed without producing a word, and err pulses for one cycle.
module instr_encoder_loader #(
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    Op,
    input  logic [5:0]    Funct,
    input  logic [3:0]    Cond,
    input  logic [3:0]    Rn,
    input  logic [3:0]    Rd,
    input  logic [11:0]   Src2,
    input  logic [23:0]   Imm24,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          full,
    output logic          err
);

    // The counter must be able to hold DEPTH itself, so it gets one extra bit.
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LIMIT = CW'(DEPTH);

    typedef enum logic {ST_LOAD, ST_FULL} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          out_xfer;
    logic          in_xfer;
    logic          room;
    logic          legal;
    logic [31:0]   enc_word;

    assign out_xfer = mem_valid & mem_ready;
    assign in_xfer  = in_valid & in_ready;

    // The word pending at address DEPTH-1 is the last one. No new field set
    // may be taken behind it, so mem_addr never advances past DEPTH-1.
    assign room = ~(mem_valid & (cnt == LAST));

    // Pack the fields. Branches carry only the L bits and the 24-bit offset.
    always_comb begin
        enc_word = {Cond, Op, Funct, Rn, Rd, Src2};
        if (Op == 2'b10) begin
            enc_word = {Cond, 2'b10, Funct[5:4], Imm24};
        end
    end

`ifdef ENC_LEGAL_CHECK_EN
    // The only legal DP commands are ADD, SUB, AND and ORR. Op=11 is undefined.
    always_comb begin
        legal = 1'b1;
        if (Op == 2'b11) begin
            legal = 1'b0;
        end else if (Op == 2'b00) begin
            case (Funct[4:1])
                4'b0100, 4'b0010, 4'b0000, 4'b1100: legal = 1'b1;
                default:                            legal = 1'b0;
            endcase
        end
    end

    // A field set is rejected when it is consumed but not legal. err flags it for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (clear) begin
            err <= 1'b0;
        end else begin
            err <= in_xfer & ~legal;
        end
    end
`else
    assign legal = 1'b1;
    assign err   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next state: the state becomes FULL when the last word is written. Only clear leaves FULL.
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = ST_LOAD;
        end else if ((state == ST_LOAD) && out_xfer && (cnt == LAST)) begin
            state_next = ST_FULL;
        end
    end

    // State-derived outputs
    always_comb begin
        full     = (state == ST_FULL);
        in_ready = (state == ST_LOAD) & (~mem_valid | mem_ready) & room;
    end

    // Word counter: it counts completed memory writes since reset or clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (out_xfer && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Output word register. A word accepted in the same cycle as a write goes one address past the written word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (clear) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
        end else if (in_xfer && legal) begin
            mem_valid <= 1'b1;
            mem_addr  <= AW'(cnt + CW'(out_xfer));
            mem_wdata <= enc_word;
        end else if (out_xfer) begin
            mem_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader. It uses directed vectors, checked against a
// transaction-level model (a pending word, a write count, and an expected memory image).
module tb_instr_encoder_loader;

    localparam int AW    = 6;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [5:0]    funct;
    logic [3:0]    cond;
    logic [3:0]    rn;
    logic [3:0]    rd;
    logic [11:0]   src2;
    logic [23:0]   imm24;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          full;
    logic          err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state
    bit          m_pv;
    int          m_pa;
    logic [31:0] m_pd;
    int          m_written;
    bit          m_full;
    bit          m_err;
    logic [31:0] exp_mem [2**AW];
    bit          exp_wr  [2**AW];
    logic [31:0] tb_mem  [2**AW];

    instr_encoder_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .Op(op), .Funct(funct), .Cond(cond), .Rn(rn), .Rd(rd),
        .Src2(src2), .Imm24(imm24),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .full(full), .err(err)
    );

    always #5 clk = ~clk;

    // Instruction memory stand-in
    always @(posedge clk) begin
        if (reset && mem_valid && mem_ready) tb_mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The word is formed by weighting each field by its bit position.
    function automatic logic [31:0] model_enc();
        logic [31:0] w;
        if (op == 2'd2)
            w = 32'(cond) * 32'h1000_0000 + 32'd2 * 32'h0400_0000
              + 32'(funct[5:4]) * 32'h0100_0000 + 32'(imm24);
        else
            w = 32'(cond) * 32'h1000_0000 + 32'(op) * 32'h0400_0000
              + 32'(funct) * 32'h0010_0000 + 32'(rn) * 32'h0001_0000
              + 32'(rd) * 32'h0000_1000 + 32'(src2);
        return w;
    endfunction

    function automatic bit model_legal();
`ifdef ENC_LEGAL_CHECK_EN
        if (op == 2'd3) return 1'b0;
        if (op == 2'd0 && !(funct[4:1] == 4'd4 || funct[4:1] == 4'd2 ||
                            funct[4:1] == 4'd0 || funct[4:1] == 4'd12)) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Input is taken only when no word is pending or the pending word leaves this cycle,
    // and only while memory space remains for the new word.
    function automatic bit exp_in_ready();
        return !m_full && (!m_pv || mem_ready) && ((m_written + int'(m_pv)) < DEPTH);
    endfunction

    task automatic model_reset();
        m_pv = 0; m_pa = 0; m_pd = '0; m_written = 0; m_full = 0; m_err = 0;
    endtask

    // Advance one clock: the task decides the transfers from the pre-edge inputs, then updates the model.
    task automatic tick();
        bit ir, ox, ix, lg;
        logic [31:0] w;
        ir = exp_in_ready();
        ox = m_pv && mem_ready;
        ix = in_valid && ir;
        lg = model_legal();
        w  = model_enc();
        @(posedge clk);
        if (ox) begin
            exp_mem[m_pa] = m_pd;
            exp_wr[m_pa]  = 1'b1;
        end
        if (clear) begin
            model_reset();
        end else begin
            if (ox) begin
                m_written++;
                if (m_written == DEPTH) m_full = 1;
            end
            m_err = ix && !lg;
            if (ix && lg) begin
                m_pv = 1; m_pa = m_written; m_pd = w;
            end else if (ox) begin
                m_pv = 0;
            end
        end
        #1;
    endtask

    task automatic set_fields(input logic [1:0] o, input logic [5:0] f, input logic [3:0] c,
                              input logic [3:0] n, input logic [3:0] d,
                              input logic [11:0] s, input logic [23:0] i);
        op = o; funct = f; cond = c; rn = n; rd = d; src2 = s; imm24 = i;
    endtask

    task automatic rand_fields();
        logic [5:0] f;
        f = 6'($urandom);
        op = 2'($urandom_range(0, 2));
        if (op == 2'd0) f[4:1] = 4'b0100;
        funct = f; cond = 4'($urandom); rn = 4'($urandom); rd = 4'($urandom);
        src2 = 12'($urandom); imm24 = 24'($urandom);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(exp_in_ready()));
            check("mem_valid", 32'(mem_valid), 32'(m_pv));
            check("full", 32'(full), 32'(m_full));
            check("err", 32'(err), 32'(m_err));
            if (m_pv) begin
                check("mem_addr", 32'(mem_addr), 32'(m_pa));
                check("mem_wdata", mem_wdata, m_pd);
            end
        end
    end

    initial begin
        for (int a = 0; a < 2**AW; a++) begin
            exp_wr[a] = 1'b0; exp_mem[a] = '0; tb_mem[a] = '0;
        end
        model_reset();
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
        set_fields(2'd0, 6'd0, 4'd0, 4'd0, 4'd0, 12'd0, 24'd0);
        #2;
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        chk_en = 1'b1;
        $display("txn: reset released");

        // DP ADD R1, R0, #5
        set_fields(2'b00, 6'b101000, 4'hE, 4'd0, 4'd1, 12'h005, 24'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("add_valid", 32'(mem_valid), 32'd1);
        check("add_addr", 32'(mem_addr), 32'd0);
        check("add_word", mem_wdata, 32'hE280_1005);
        $display("txn: ADD addr=%0d word=%h", mem_addr, mem_wdata);

        // Backpressure: branch waiting behind the ADD for 5 cycles
        set_fields(2'b10, 6'b100000, 4'hE, 4'd0, 4'd0, 12'd0, 24'hFFFFFE);
        in_valid = 1'b1;
        repeat (5) tick();
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_word_held", mem_wdata, 32'hE280_1005);
        check("bp_addr_held", 32'(mem_addr), 32'd0);
        mem_ready = 1'b1;
        tick();
        check("mem0_add", tb_mem[0], 32'hE280_1005);
        check("br_addr", 32'(mem_addr), 32'd1);
        check("br_word", mem_wdata, 32'hEAFF_FFFE);
        $display("txn: B addr=%0d word=%h", mem_addr, mem_wdata);

        // LDR R2, [R0] is accepted in the same cycle that the branch is written.
        set_fields(2'b01, 6'b011001, 4'hE, 4'd0, 4'd2, 12'd0, 24'd0);
        tick();
        check("ldr_addr", 32'(mem_addr), 32'd2);
        check("ldr_word", mem_wdata, 32'hE590_2000);
        $display("txn: LDR addr=%0d word=%h", mem_addr, mem_wdata);

        // Op=11
        set_fields(2'b11, 6'b000000, 4'hE, 4'd0, 4'd0, 12'd0, 24'd0);
        tick();
`ifdef ENC_LEGAL_CHECK_EN
        check("op11_err", 32'(err), 32'd1);
        check("op11_novalid", 32'(mem_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        check("op11_err_clr", 32'(err), 32'd0);
        set_fields(2'b00, 6'b011110, 4'hE, 4'd1, 4'd1, 12'd0, 24'd0);
        in_valid = 1'b1;
        tick();
        check("badcmd_err", 32'(err), 32'd1);
        check("badcmd_novalid", 32'(mem_valid), 32'd0);
`else
        check("op11_addr", 32'(mem_addr), 32'd3);
        check("op11_word", mem_wdata, 32'hEC00_0000);
`endif
        $display("txn: Op=11 valid=%0d err=%0d", mem_valid, err);

        // Stream until the memory is full.
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_fields();
            tick();
            $display("txn: stream %0d valid=%0d addr=%0d full=%0d", i, mem_valid, mem_addr, full);
        end
        in_valid = 1'b0;
        tick();
        check("fill_full", 32'(full), 32'd1);
        check("fill_in_ready", 32'(in_ready), 32'd0);

        // Clear out of FULL, then write again from address 0.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_full", 32'(full), 32'd0);
        mem_ready = 1'b0;
        set_fields(2'b00, 6'b001001, 4'h0, 4'd3, 4'd4, 12'h0AB, 24'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_clr_addr", 32'(mem_addr), 32'd0);
        check("post_clr_word", mem_wdata, 32'h0093_40AB);
        $display("txn: after clear addr=%0d word=%h", mem_addr, mem_wdata);

        // Clear while a word is pending under backpressure
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_pend_drop", 32'(mem_valid), 32'd0);
        mem_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_fields();
            tick();
        end
        in_valid = 1'b0;
        tick();
        $display("txn: two words after clear, full=%0d", full);

        // Reset while a word is pending
        mem_ready = 1'b0;
        rand_fields();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_mid_valid", 32'(mem_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        mem_ready = 1'b1;
        set_fields(2'b01, 6'b011000, 4'hE, 4'd1, 4'd5, 12'h004, 24'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rst_mid_addr", 32'(mem_addr), 32'd0);
        check("rst_mid_word", mem_wdata, 32'hE581_5004);
        tick();
        $display("txn: after mid reset word written, valid=%0d", mem_valid);

        // Memory image compared with the model
        chk_en = 1'b0;
        for (int a = 0; a < 2**AW; a++) begin
            if (exp_wr[a]) check("mem_image", tb_mem[a], exp_mem[a]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
